// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    StStartup = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2
  } state_e;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the load in EX.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  memread,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  loaduse
);

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign loaduse = memread & (rd != '0) & ((rd == rs1_addr) | (rd == rs2_addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: start-up fill, load-use stall, branch flush, memory freeze, watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned MAX_WAIT     = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_write_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  stall_all_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      memwait_cnt_o
);

  localparam logic [3:0]  StartLast = 4'(START_CYCLES - 1);
  localparam logic [15:0] MaxWait   = 16'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  start_cnt_q, start_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic        loaduse;
  logic        memstall;

  hazard_detect u_hazard_detect (
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .memread  (id_ex_memread_i),
    .rd       (id_ex_rd_i),
    .loaduse  (loaduse)
  );

  assign memstall = mem_req_i & ~mem_ack_i;

  always_comb begin
    state_d        = state_q;
    start_cnt_d    = start_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;
    pc_write_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    stall_all_o    = 1'b0;

    unique case (state_q)
      StStartup: begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (start_cnt_q >= StartLast) begin
          state_d     = StRun;
          start_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (memstall) begin
          stall_all_o   = 1'b1;
          if_id_stall_o = 1'b1;
          state_d       = StMemWait;
        end else if (loaduse) begin
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          if_id_flush_o = 1'b1;
          pc_write_o    = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
      StMemWait: begin
        stall_all_o   = 1'b1;
        if_id_stall_o = 1'b1;
        if (mem_ack_i) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = (wait_cnt_q >= MaxWait) ? wait_cnt_q : wait_cnt_q + 16'd1;
          if (wait_cnt_d == MaxWait) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        state_d        = StStartup;
        start_cnt_d    = '0;
      end
    endcase

    // The reset cycle itself presents the start-up control set.
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      stall_all_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StStartup;
      start_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // In RUN, bubble alone marks load-use and flush alone marks a taken branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if ((state_q == StRun) && id_ex_bubble_o) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if ((state_q == StRun) && if_id_flush_o) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
      if (stall_all_o) begin
        memwait_cnt_q <= sat_inc(memwait_cnt_q);
      end
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;
`else
  assign stall_cnt_o   = '0;
  assign flush_cnt_o   = '0;
  assign memwait_cnt_o = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates the stall and flush controls for IF_ID, the bubble control for ID_EX, the PC write enable, and a global freeze while the data memory is busy.
- Also holds the start-up fill sequence after reset and a memory-wait watchdog.
- Sits beside the ID stage and is fed by the ID decode, ID_EX and data-memory interface signals.

Parameters:
- START_CYCLES, 2: number of cycles after reset during which PC is held and IF_ID is flushed (range 1..15).
- MAX_WAIT, 1023: MEM_WAIT cycle count at which err_o is raised (range 1..65535).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rs1_addr_i  in  5  ID-stage source register 1.
- rs2_addr_i  in  5  ID-stage source register 2.
- id_ex_memread_i  in  1  instruction in EX is a load.
- id_ex_rd_i  in  5  destination register of the instruction in EX.
- branch_taken_i  in  1  ID-stage branch/jump resolved taken.
- mem_req_i  in  1  MEM stage has an outstanding data access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC register update enable.
- if_id_stall_o  out  1  IF_ID hold.
- if_id_flush_o  out  1  IF_ID instruction zeroed.
- id_ex_bubble_o  out  1  ID_EX control fields zeroed.
- stall_all_o  out  1  freeze ID_EX, EX_MEM and MEM_WB.
- err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  32  load-use stall cycles.
- flush_cnt_o  out  32  branch flushes.
- memwait_cnt_o  out  32  memory freeze cycles.

Behaviour:
- Reset (synchronous, active-high):
  - state=STARTUP, start counter=0, wait counter=0, err_o=0, perf counters=0.
  - During the reset cycle outputs follow the STARTUP rules.
- States: STARTUP, RUN, MEM_WAIT (2-bit encoding, shared package).
- STARTUP:
  - Outputs: pc_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, if_id_stall_o=0, stall_all_o=0.
  - Counts START_CYCLES cycles, then goes to RUN.
  - All hazard inputs are ignored.
- RUN, decision per cycle (all outputs combinational from state plus inputs, zero latency):
  - Signal definitions:
    - loaduse = id_ex_memread_i & (id_ex_rd_i!=0) & (id_ex_rd_i==rs1_addr_i | id_ex_rd_i==rs2_addr_i).
    - memstall = mem_req_i & ~mem_ack_i.
  - Priority 1, memstall:
    - Outputs: stall_all_o=1, pc_write_o=0, if_id_stall_o=1, flush=0, bubble=0.
    - Next state MEM_WAIT. Load-use and branch are suppressed and re-evaluated after the freeze.
  - Priority 2, loaduse:
    - Outputs: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1, if_id_flush_o=0.
    - branch_taken_i is suppressed because its operands are not yet valid.
    - Exactly one stall cycle per load-use pair; the hazard clears when the load advances.
  - Priority 3, branch_taken_i: if_id_flush_o=1, pc_write_o=1.
  - Otherwise: pc_write_o=1, all other controls 0.
- MEM_WAIT:
  - Outputs as in priority 1.
  - Wait counter increments, saturating at MAX_WAIT.
  - Counter reaching MAX_WAIT sets err_o, which stays 1 until rst_i.
  - mem_ack_i=1: outputs for that cycle are still the freeze set; next state RUN; wait counter cleared.
  - mem_ack_i and mem_req_i are sampled only in MEM_WAIT and RUN.
- Edge cases:
  - rd=x0 never stalls.
  - rs1==rs2==rd produces a single stall.
  - mem_req_i with mem_ack_i in the same RUN cycle produces no freeze.
  - Reset mid-MEM_WAIT returns to STARTUP next edge; err_o is cleared.
  - Output encodings are mutually consistent: flush and stall are never both 1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: three 32-bit saturating counters.
  - stall_cnt_o: +1 per RUN load-use cycle.
  - flush_cnt_o: +1 per RUN branch flush.
  - memwait_cnt_o: +1 per cycle with stall_all_o=1.
  - All cleared by rst_i.
- Undefined: the ports remain and are tied to 0; no counter flops.

Decomposition:
- Package hazard_pkg:
  - State enum/localparams (STARTUP=0, RUN=1, MEM_WAIT=2).
  - REG_ADDR_W=5.
  - CNT_W=32.
- One sub-module, hazard_detect: purely combinational loaduse compare, instantiated once.
- Counters and FSM stay in hazard_ctrl.

Test Plan:
- Reset and start-up:
  - Stimulus: rst_i high for 1 cycle, then low.
  - Required response: pc_write_o=0 and if_id_flush_o=1 for exactly 2 cycles, then pc_write_o=1 with all controls 0.
- Load-use:
  - Stimulus: id_ex_memread_i=1, id_ex_rd_i=5, rs2_addr_i=5 for 1 cycle.
  - Required response: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1 that cycle. Repeat with rd=0 → no stall.
- Branch:
  - Stimulus: branch_taken_i=1, no hazard.
  - Required response: if_id_flush_o=1, pc_write_o=1.
  - Stimulus: same cycle as a load-use.
  - Required response: stall only, flush=0.
- Memory freeze:
  - Stimulus: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack.
  - Required response: stall_all_o=1 for 4 cycles including the ack cycle, then RUN; memwait_cnt_o=4 with HAZARD_PERF_CNT_EN.
- Watchdog:
  - Stimulus: MAX_WAIT=8, mem_req_i held without ack.
  - Required response: err_o rises after 8 MEM_WAIT cycles and stays 1 after ack. rst_i mid-wait gives state STARTUP and err_o=0.
